pipeline_run_ctrl: RTL and testbench

Run controller for the five-stage pipelined CPU. Sequences execution by driving the CPU's `start_i` enable, supports free-run, single-step and abort, detects program end by PC match plus pipeline drain, and keeps saturating cycle, stall and flush counters. These counters give a hardware version of the stall/flush bookkeeping the bench does today. Sits beside `CPU`, fed by the hazard-detection and branch signals.

---
 rtl/pipe_ctrl_pkg.sv | 14 +
 rtl/sat_counter.sv | 22 ++
 rtl/pipeline_run_ctrl.sv | 117 +++++++++++
 tb/tb_pipeline_run_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline run controller: run-state encoding and defaults.
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_STEP  = 3'd3,
    ST_DONE  = 3'd4
  } run_state_e;

  localparam int DRAIN_CYCLES_DEF = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (v == '1) ? v : v + W'(1);
  endfunction

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)      cnt_o <= '0;
    else if (clr_i)  cnt_o <= '0;
    else if (inc_i)  cnt_o <= sat_inc(cnt_o);
  end

endmodule

// File: rtl/pipeline_run_ctrl.sv
// Run controller for the five-stage CPU: gates the CPU enable for free-run, single-step
// and abort, ends a run on cycle limit or end-PC plus drain, and counts cycles/stalls/flushes.
module pipeline_run_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int PC_W         = 32,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             step_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] cycle_limit_i,
  input  logic             end_pc_en_i,
  input  logic [PC_W-1:0]  end_pc_i,
  input  logic [PC_W-1:0]  pc_i,
  input  logic             stall_i,
  input  logic             branch_i,
  input  logic             flush_i,
  output logic             cpu_en_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [3:0] DRAIN_N = 4'(DRAIN_CYCLES);

  run_state_e state_q, state_d;
  logic [3:0] drain_q, drain_d;
  logic       start_q;
  logic       start_rise, limit_hit, pc_hit, cnt_clr;

  assign start_rise = start_i & ~start_q;
  // The +1 wraps to zero once the count saturates, so a saturated run never hits a limit.
  assign limit_hit  = (cycle_limit_i != '0) && ((cycle_cnt_o + CNT_W'(1)) == cycle_limit_i);
  assign pc_hit     = end_pc_en_i && (pc_i == end_pc_i);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      start_q <= start_i;
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    cnt_clr = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_rise) begin
          state_d = ST_RUN;
          drain_d = '0;
          cnt_clr = 1'b1;
        end else if (step_i) begin
          state_d = ST_STEP;
        end
      end
      ST_STEP: state_d = abort_i ? ST_DONE : ST_IDLE;
      ST_RUN: begin
        if (abort_i || limit_hit) begin
          state_d = ST_DONE;
        end else if (pc_hit) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q + 4'd1;
        if (abort_i || limit_hit || (drain_d == DRAIN_N)) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Decoded from the state register alone so an asynchronous reset drops the enable at once.
  assign cpu_en_o = (state_q == ST_RUN) || (state_q == ST_DRAIN) || (state_q == ST_STEP);
  assign busy_o   = cpu_en_o;
  assign done_o   = (state_q == ST_DONE);
  assign state_o  = state_q;

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (cnt_clr),
    .inc_i (cpu_en_o),
    .cnt_o (cycle_cnt_o)
  );

  // A stall flagged alongside a branch is the hazard unit reacting to the branch, not a load-use stall.
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (cnt_clr),
    .inc_i (cpu_en_o & stall_i & ~branch_i),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (cnt_clr),
    .inc_i (cpu_en_o & flush_i),
    .cnt_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Bench for pipeline_run_ctrl with narrow counters so saturation is reachable quickly.
module tb_pipeline_run_ctrl;

  localparam int CNT_W = 4;
  localparam int PC_W  = 8;
  localparam int DRN   = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam int NCYC  = 40;

  logic             clk = 1'b0;
  logic             rst_i = 1'b0;
  logic             start_i = 1'b0, step_i = 1'b0, abort_i = 1'b0;
  logic [CNT_W-1:0] cycle_limit_i = '0;
  logic             end_pc_en_i = 1'b0;
  logic [PC_W-1:0]  end_pc_i = '0, pc_i = '0;
  logic             stall_i = 1'b0, branch_i = 1'b0, flush_i = 1'b0;
  logic             cpu_en_o, busy_o, done_o;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] cycle_cnt_o, stall_cnt_o, flush_cnt_o;

  int tests = 0;
  int fails = 0;

  // Per-run scenario: values driven during enabled cycle c (1-based).
  logic [PC_W-1:0] pcs [1:NCYC];
  bit              stl [1:NCYC];
  bit              brn [1:NCYC];
  bit              fl  [1:NCYC];
  int              abort_at, lim;
  bit              end_en;
  logic [PC_W-1:0] endpc;

  always #5 clk = ~clk;

  pipeline_run_ctrl #(.CNT_W(CNT_W), .PC_W(PC_W), .DRAIN_CYCLES(DRN)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .step_i        (step_i),
    .abort_i       (abort_i),
    .cycle_limit_i (cycle_limit_i),
    .end_pc_en_i   (end_pc_en_i),
    .end_pc_i      (end_pc_i),
    .pc_i          (pc_i),
    .stall_i       (stall_i),
    .branch_i      (branch_i),
    .flush_i       (flush_i),
    .cpu_en_o      (cpu_en_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .state_o       (state_o),
    .cycle_cnt_o   (cycle_cnt_o),
    .stall_cnt_o   (stall_cnt_o),
    .flush_cnt_o   (flush_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr_scn();
    for (int i = 1; i <= NCYC; i++) begin
      pcs[i] = '0; stl[i] = 0; brn[i] = 0; fl[i] = 0;
    end
    abort_at = 0; lim = 0; end_en = 0; endpc = '0;
  endtask

  // Reference: a run lasts until the earliest of abort, limit, or end-PC match + drain.
  function automatic int exp_len();
    int t = 1000;
    if (abort_at != 0) t = abort_at;
    if (lim != 0 && lim < t) t = lim;
    if (end_en) begin
      for (int c = 1; c <= NCYC; c++) begin
        if (pcs[c] == endpc) begin
          if (c + DRN < t) t = c + DRN;
          break;
        end
      end
    end
    return t;
  endfunction

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic run_chk(input string tag, input bit chk_no_drain);
    int c, elen, es, ef;
    bit saw_drain;
    elen = exp_len();
    es = 0; ef = 0;
    for (int i = 1; i <= elen && i <= NCYC; i++) begin
      if (stl[i] && !brn[i]) es++;
      if (fl[i]) ef++;
    end
    @(negedge clk);
    cycle_limit_i = CNT_W'(lim); end_pc_en_i = end_en; end_pc_i = endpc;
    abort_i = 0; stall_i = 0; branch_i = 0; flush_i = 0; pc_i = '0;
    start_i = 1;
    @(posedge clk);
    c = 0; saw_drain = 0;
    @(negedge clk);
    while (cpu_en_o === 1'b1 && c < 60) begin
      if (state_o == 3'd2) saw_drain = 1;
      c++;
      if (c <= NCYC) begin
        pc_i = pcs[c]; stall_i = stl[c]; branch_i = brn[c]; flush_i = fl[c];
      end
      abort_i = (c == abort_at);
      @(negedge clk);
    end
    abort_i = 0; stall_i = 0; branch_i = 0; flush_i = 0;
    check({tag, " en_cycles"}, c, elen);
    check({tag, " cycle_cnt"}, cycle_cnt_o, sat(elen));
    check({tag, " stall_cnt"}, stall_cnt_o, sat(es));
    check({tag, " flush_cnt"}, flush_cnt_o, sat(ef));
    check({tag, " done"}, done_o, 1);
    if (chk_no_drain) check({tag, " drain_seen"}, saw_drain, 0);
    if (cpu_en_o === 1'b1) begin
      abort_i = 1;
      @(negedge clk);
      abort_i = 0;
    end
    // start_i is still high here: the block must sit in DONE.
    repeat (2) @(negedge clk);
    check({tag, " held_start_state"}, state_o, 4);
    check({tag, " held_start_cnt"}, cycle_cnt_o, sat(elen));
    start_i = 0;
  endtask

  initial begin
    #3;
    check("rst state", state_o, 0);
    check("rst cpu_en", cpu_en_o, 0);
    check("rst cnt", {done_o, busy_o, cycle_cnt_o, stall_cnt_o, flush_cnt_o}, 0);
    @(negedge clk); rst_i = 1;

    // Reset in the middle of a run, between clock edges.
    @(negedge clk); start_i = 1; stall_i = 1; flush_i = 1;
    repeat (4) @(posedge clk);
    #2 rst_i = 0;
    #1;
    check("midrst cpu_en", cpu_en_o, 0);
    check("midrst outs", {busy_o, done_o, state_o}, 0);
    check("midrst cnts", {cycle_cnt_o, stall_cnt_o, flush_cnt_o}, 0);
    @(negedge clk); start_i = 0; stall_i = 0; flush_i = 0; rst_i = 1;

    // Three single steps from IDLE.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); step_i = 1;
      @(posedge clk);
      @(negedge clk); step_i = 0;
      check("step en", cpu_en_o, 1);
      @(negedge clk);
      check("step back", {cpu_en_o, state_o}, 0);
    end
    check("step cycle_cnt", cycle_cnt_o, 3);

    // start and step together: start wins and clears counters.
    @(negedge clk); start_i = 1; step_i = 1;
    @(posedge clk); #1;
    check("prio start state", state_o, 1);
    check("prio start cnt", cycle_cnt_o, 0);
    @(negedge clk); step_i = 0; abort_i = 1;
    @(negedge clk); abort_i = 0;
    check("prio abort state", state_o, 4);
    check("prio abort cnt", cycle_cnt_o, 1);
    @(negedge clk); start_i = 0;

    // Limit run: 10 cycles, stalls on 2,4,6 (4 with branch), flushes on 3,7.
    clr_scn(); lim = 10;
    stl[2] = 1; stl[4] = 1; stl[6] = 1; brn[4] = 1; fl[3] = 1; fl[7] = 1;
    run_chk("limit", 0);

    // End PC 0x20 reached on cycle 8.
    clr_scn(); end_en = 1; endpc = 8'h20;
    for (int i = 1; i <= NCYC; i++) pcs[i] = PC_W'(i * 4);
    run_chk("endpc", 0);

    // Abort, limit and end-PC all on cycle 6.
    clr_scn(); lim = 6; end_en = 1; endpc = 8'h55; pcs[6] = 8'h55; abort_at = 6;
    run_chk("prio_all", 1);

    // Limit and end-PC on the same cycle: limit wins.
    clr_scn(); lim = 8; end_en = 1; endpc = 8'h33; pcs[8] = 8'h33; pcs[9] = 8'h33;
    run_chk("lim_vs_pc", 1);

    // Saturation: no limit, everything counting for 30 cycles.
    clr_scn(); abort_at = 30;
    for (int i = 1; i <= NCYC; i++) begin stl[i] = 1; fl[i] = 1; pcs[i] = 8'hff; end
    run_chk("saturate", 0);

    for (int r = 0; r < 20; r++) begin
      clr_scn();
      lim      = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, CMAX)) : 0;
      end_en   = ($urandom_range(0, 1) != 0);
      endpc    = PC_W'($urandom_range(0, 15));
      abort_at = int'($urandom_range(3, 38));
      for (int i = 1; i <= NCYC; i++) begin
        pcs[i] = PC_W'($urandom_range(0, 31));
        stl[i] = ($urandom_range(0, 1) != 0);
        brn[i] = ($urandom_range(0, 3) == 0);
        fl[i]  = ($urandom_range(0, 2) == 0);
      end
      run_chk($sformatf("rand%0d", r), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
